inst_mem_loader: RTL
====================

Name: inst_mem_loader

Overview:
- Writer side of the 56-bit instruction/data memory word interface.
- Accepts a byte stream over a valid/ready handshake and packs each group of 7 bytes into one 56-bit word.
- Issues single-cycle write strobes (`mem_write`, `mem_addr`, `mem_data`) into a word memory at sequential addresses.
- Used to load programs and data at run time instead of relying on file preload at simulation start.

Parameters:
- WORD_WIDTH, 56, memory word width in bits; must equal 8*BYTES_PER_WORD.
- BYTES_PER_WORD, 7, bytes packed per word.
- ADDR_WIDTH, 8, memory address width (256 words).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any state.
- base_addr  in  ADDR_WIDTH  first word address, latched on accepted start.
- word_count  in  ADDR_WIDTH+1  words to load, latched on accepted start; 0 = none; values >256 clamp to 256.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_write  out  1  one-cycle word write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  WORD_WIDTH  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes normally.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE.
  - byte_ready, mem_write, busy, done = 0; mem_addr=0; mem_data=0.
  - Byte counter, address counter, remaining count and shift register = 0.
- States: IDLE, COLLECT, WRITE, DONE.
- Output decode per state:
  - IDLE: busy=0, byte_ready=0.
  - COLLECT: busy=1, byte_ready=1.
  - WRITE: busy=1, byte_ready=0, mem_write=1.
  - DONE: busy=0, done=1.
- IDLE:
  - start=1 and abort=0: latch base_addr into the address counter and the clamped word_count into remaining; clear byte counter.
  - Next state is DONE if the clamped count is 0, otherwise COLLECT.
  - start is ignored in all other states.
- COLLECT:
  - A byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
  - On acceptance: shift register <= {shift[47:0], byte_data}, so the first byte becomes bits [55:48] (big-endian, matching hex word order).
  - The byte counter increments 0..6.
  - Acceptance of the 7th byte (counter=6) moves to WRITE.
  - byte_valid=0 stalls the load indefinitely with no timeout.
- WRITE (exactly one cycle):
  - mem_write=1, mem_addr=address counter, mem_data=packed word.
  - The memory captures the word on the next rising edge.
  - At exit: the address counter increments modulo 256 (0xFF wraps to 0x00); remaining decrements; byte counter clears.
  - Next state is DONE if remaining was 1, otherwise COLLECT.
  - A byte presented during WRITE is not consumed and must be held by the source.
- DONE (one cycle): done=1, then return to IDLE.
- mem_addr and mem_data hold their last written values after a write. mem_write is never high outside WRITE.
- Latency and throughput:
  - mem_write rises one cycle after the edge that accepts the 7th byte.
  - done rises one cycle after the last WRITE.
  - Peak throughput is one word per 8 cycles.
- abort:
  - Takes priority over start and all state transitions; next state is IDLE.
  - Partial bytes are discarded, no mem_write is issued, and no done pulse is produced.
  - If abort is asserted during WRITE, that cycle's write still occurs (strobe already out); the state then goes to IDLE.
- Reset asserted mid-load: outputs clear immediately (asynchronously) and no further writes occur.

Test Plan:
- Reset, start with base_addr=0x64 and word_count=1, bytes 00 00 00 00 00 00 2D with byte_valid held high -> exactly one mem_write with mem_addr=0x64 and mem_data=56'h2D; done pulses one cycle later; busy=0 afterwards.
- Bytes 11 22 33 44 55 66 77 -> mem_data=56'h11223344556677, confirming byte order.
- base_addr=0xFF, word_count=2, 14 bytes -> writes at 0xFF then 0x00; one done pulse after the second write.
- Random byte_valid gaps, plus a byte held valid across WRITE -> byte_ready=0 during WRITE, no byte lost or duplicated, data still exact.
- word_count=0 -> no mem_write; done pulses on the second cycle after start; a start asserted during COLLECT is ignored.
- abort after 3 bytes, then a new load of 1 word -> no write from the aborted load; the new word contains only the new bytes. rst asserted mid-COLLECT -> all outputs 0 immediately.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Byte-stream to 56-bit word loader: packs 7 bytes big-endian per word
// and issues one write strobe per word at sequential addresses.
module inst_mem_loader #(
  parameter int WORD_WIDTH     = 56,
  parameter int BYTES_PER_WORD = 7,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE, COLLECT, WRITE, DONE
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         byte_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   count_clamped;
  logic [WORD_WIDTH-1:0] shift;
  logic [WORD_WIDTH-1:0] shift_nx;
  logic                  accept;
  logic                  last_byte;

  assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign accept        = byte_valid && byte_ready;
  assign last_byte     = (byte_cnt == LAST_IDX);
  assign shift_nx      = {shift[WORD_WIDTH-9:0], byte_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state_nx = (count_clamped == '0) ? DONE : COLLECT;
        end
        COLLECT: begin
          if (accept && last_byte) state_nx = WRITE;
        end
        WRITE: begin
          state_nx = (remaining == (ADDR_WIDTH+1)'(1)) ? DONE : COLLECT;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = 1'b0;
    byte_ready = 1'b0;
    mem_write  = 1'b0;
    done       = 1'b0;
    unique case (state)
      COLLECT: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // mem_addr/mem_data load with the completed word so they hold afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt  <= '0;
      addr_cnt  <= '0;
      remaining <= '0;
      shift     <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else if (abort) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_cnt  <= base_addr;
            remaining <= count_clamped;
            byte_cnt  <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            shift <= shift_nx;
            if (last_byte) begin
              byte_cnt <= '0;
              mem_addr <= addr_cnt;
              mem_data <= shift_nx;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        WRITE: begin
          addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
          remaining <= remaining - (ADDR_WIDTH+1)'(1);
          byte_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
